// File: rtl/bster_cmd_arbiter.sv
// Round-robin command arbiter in front of bster: merges per-client command
// streams into one registered stream and routes in-order completions back by tag.
module bster_cmd_arbiter #(
  parameter int unsigned NB_CHANNEL = 4,
  parameter int unsigned CMD_WIDTH  = 128,
  parameter int unsigned TAG_DEPTH  = 8
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic [NB_CHANNEL-1:0]            ch_en,
  input  logic [NB_CHANNEL-1:0]            s_cmd_tvalid,
  output logic [NB_CHANNEL-1:0]            s_cmd_tready,
  input  logic [NB_CHANNEL*CMD_WIDTH-1:0]  s_cmd_tdata,
  output logic                             m_cmd_tvalid,
  input  logic                             m_cmd_tready,
  output logic [CMD_WIDTH-1:0]             m_cmd_tdata,
  input  logic                             s_cpl_tvalid,
  output logic                             s_cpl_tready,
  input  logic [CMD_WIDTH-1:0]             s_cpl_tdata,
  output logic [NB_CHANNEL-1:0]            m_cpl_tvalid,
  input  logic [NB_CHANNEL-1:0]            m_cpl_tready,
  output logic [CMD_WIDTH-1:0]             m_cpl_tdata,
  output logic [$clog2(TAG_DEPTH+1)-1:0]   outstanding,
  output logic                             orphan_cpl
);

  localparam int unsigned CH_W = $clog2(NB_CHANNEL);
  localparam int unsigned AW   = $clog2(TAG_DEPTH);
  localparam int unsigned CW   = $clog2(TAG_DEPTH+1);

  logic                 cmd_valid_q, cmd_valid_d;
  logic [CMD_WIDTH-1:0] cmd_data_q,  cmd_data_d;
  logic [CH_W-1:0]      rr_ptr_q,    rr_ptr_d;
  logic [CH_W-1:0]      tag_mem_q [TAG_DEPTH];
  logic [CH_W-1:0]      tag_mem_d [TAG_DEPTH];
  logic [AW-1:0]        wr_ptr_q,    wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q,    rd_ptr_d;
  logic [CW-1:0]        count_q,     count_d;
  logic                 orphan_q,    orphan_d;

  logic [NB_CHANNEL-1:0] elig;
  logic                  found;
  logic [CH_W-1:0]       win;
  int unsigned           scan_idx;
  logic                  load_en;
  logic                  full;
  logic                  empty;
  logic                  grant;
  logic                  pop;
  logic [CH_W-1:0]       head;

  assign load_en = !cmd_valid_q || m_cmd_tready;
  assign full    = (count_q == CW'(TAG_DEPTH));
  assign empty   = (count_q == '0);
  assign head    = tag_mem_q[rd_ptr_q];

  // Scan from rr_ptr upward, wrapping; first eligible channel wins.
  always_comb begin
    elig     = s_cmd_tvalid & ch_en;
    found    = 1'b0;
    win      = '0;
    scan_idx = 0;
    for (int unsigned off = 0; off < NB_CHANNEL; off++) begin
      scan_idx = 32'(rr_ptr_q) + off;
      if (scan_idx >= NB_CHANNEL) scan_idx = scan_idx - NB_CHANNEL;
      if (!found && elig[CH_W'(scan_idx)]) begin
        found = 1'b1;
        win   = CH_W'(scan_idx);
      end
    end
  end

  // A full tag FIFO blocks the grant even if a completion pops this cycle.
  assign grant = found && load_en && !full && !areset;

  always_comb begin
    s_cmd_tready = '0;
    if (grant) s_cmd_tready[win] = 1'b1;
  end

  always_comb begin
    m_cpl_tvalid = '0;
    if (!areset && !empty && s_cpl_tvalid) m_cpl_tvalid[head] = 1'b1;
  end

  // With nothing outstanding, completions are accepted and dropped as orphans.
  assign s_cpl_tready = !areset && (empty || m_cpl_tready[head]);
  assign pop          = s_cpl_tvalid && s_cpl_tready && !empty;
  assign m_cpl_tdata  = s_cpl_tdata;

  always_comb begin
    cmd_valid_d = cmd_valid_q;
    cmd_data_d  = cmd_data_q;
    rr_ptr_d    = rr_ptr_q;
    tag_mem_d   = tag_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    orphan_d    = s_cpl_tvalid && empty && !areset;

    if (load_en) begin
      cmd_valid_d = grant;
      if (grant) cmd_data_d = s_cmd_tdata[32'(win)*CMD_WIDTH +: CMD_WIDTH];
    end

    if (grant) begin
      rr_ptr_d            = (32'(win) == NB_CHANNEL - 1) ? '0 : win + CH_W'(1);
      tag_mem_d[wr_ptr_q] = win;
      wr_ptr_d            = wr_ptr_q + AW'(1);
    end

    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

    case ({grant, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      cmd_valid_q <= 1'b0;
      cmd_data_q  <= '0;
      rr_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      orphan_q    <= 1'b0;
    end else begin
      cmd_valid_q <= cmd_valid_d;
      cmd_data_q  <= cmd_data_d;
      rr_ptr_q    <= rr_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      orphan_q    <= orphan_d;
    end
    tag_mem_q <= tag_mem_d;
  end

  assign m_cmd_tvalid = cmd_valid_q;
  assign m_cmd_tdata  = cmd_data_q;
  assign outstanding  = count_q;
  assign orphan_cpl   = orphan_q;

endmodule

// File: tb/tb_bster_cmd_arbiter.sv
// Scoreboard bench for bster_cmd_arbiter: directed scenarios queue expected
// command and completion beats; a negedge monitor pops and compares them.
module tb_bster_cmd_arbiter;

  localparam int unsigned NB = 4;
  localparam int unsigned CW = 128;
  localparam int unsigned TD = 8;

  logic                 aclk = 1'b0;
  logic                 areset;
  logic [NB-1:0]        ch_en;
  logic [NB-1:0]        s_cmd_tvalid;
  logic [NB-1:0]        s_cmd_tready;
  logic [NB*CW-1:0]     s_cmd_tdata;
  logic                 m_cmd_tvalid;
  logic                 m_cmd_tready;
  logic [CW-1:0]        m_cmd_tdata;
  logic                 s_cpl_tvalid;
  logic                 s_cpl_tready;
  logic [CW-1:0]        s_cpl_tdata;
  logic [NB-1:0]        m_cpl_tvalid;
  logic [NB-1:0]        m_cpl_tready;
  logic [CW-1:0]        m_cpl_tdata;
  logic [$clog2(TD+1)-1:0] outstanding;
  logic                 orphan_cpl;

  typedef struct {
    logic [NB-1:0] vld;
    logic [CW-1:0] data;
  } cpl_exp_t;

  logic [CW-1:0] exp_cmd[$];
  cpl_exp_t      exp_cpl[$];
  int            checks   = 0;
  int            failures = 0;
  int            beat_no  = 0;
  bit            done     = 1'b0;

  always #5 aclk = ~aclk;

  bster_cmd_arbiter #(
    .NB_CHANNEL (NB),
    .CMD_WIDTH  (CW),
    .TAG_DEPTH  (TD)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .ch_en        (ch_en),
    .s_cmd_tvalid (s_cmd_tvalid),
    .s_cmd_tready (s_cmd_tready),
    .s_cmd_tdata  (s_cmd_tdata),
    .m_cmd_tvalid (m_cmd_tvalid),
    .m_cmd_tready (m_cmd_tready),
    .m_cmd_tdata  (m_cmd_tdata),
    .s_cpl_tvalid (s_cpl_tvalid),
    .s_cpl_tready (s_cpl_tready),
    .s_cpl_tdata  (s_cpl_tdata),
    .m_cpl_tvalid (m_cpl_tvalid),
    .m_cpl_tready (m_cpl_tready),
    .m_cpl_tdata  (m_cpl_tdata),
    .outstanding  (outstanding),
    .orphan_cpl   (orphan_cpl)
  );

  function automatic logic [CW-1:0] payload(input int ch);
    return {4{24'hA5C3E1, 8'(ch)}};
  endfunction

  function automatic logic [NB-1:0] onehot(input int ch);
    logic [NB-1:0] v;
    v = '0;
    v[ch] = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_cpl_data();
    beat_no++;
    s_cpl_tdata = {96'h0, 32'hF00D_0000 + 32'(beat_no)};
  endtask

  task automatic expect_cpl(input int ch);
    cpl_exp_t e;
    e.vld  = onehot(ch);
    e.data = s_cpl_tdata;
    exp_cpl.push_back(e);
  endtask

  task automatic cpl_beat(input int ch);
    set_cpl_data();
    s_cpl_tvalid = 1'b1;
    expect_cpl(ch);
    step();
  endtask

  initial begin
    areset       = 1'b1;
    ch_en        = '1;
    s_cmd_tvalid = '1;
    m_cmd_tready = 1'b1;
    s_cpl_tvalid = 1'b1;
    s_cpl_tdata  = '0;
    m_cpl_tready = '1;
    for (int ch = 0; ch < NB; ch++) s_cmd_tdata[ch*CW +: CW] = payload(ch);

    fork
      begin : stim
        // reset: handshakes gated, registers cleared
        step(); step();
        #1;
        check("rst_s_cmd_tready", s_cmd_tready, '0);
        check("rst_m_cpl_tvalid", m_cpl_tvalid, '0);
        check("rst_s_cpl_tready", s_cpl_tready, '0);
        check("rst_m_cmd_tvalid", m_cmd_tvalid, '0);
        check("rst_m_cmd_tdata", m_cmd_tdata, '0);
        check("rst_outstanding", outstanding, '0);
        check("rst_orphan", orphan_cpl, '0);
        areset = 1'b0; s_cmd_tvalid = '0; s_cpl_tvalid = 1'b0;
        step();
        check("post_rst_orphan", orphan_cpl, '0);
        check("post_rst_outstanding", outstanding, '0);

        // round robin over all channels
        s_cmd_tvalid = '1;
        for (int i = 0; i < 5; i++) begin
          #1;
          check("rr_grant", s_cmd_tready, onehot(i % 4));
          exp_cmd.push_back(payload(i % 4));
          step();
        end
        s_cmd_tvalid = '0;
        #1;
        check("rr_outstanding", outstanding, 5);
        check("rr_last_valid", m_cmd_tvalid, 1);
        step();
        check("rr_reg_cleared", m_cmd_tvalid, 0);
        cpl_beat(0); cpl_beat(1); cpl_beat(2); cpl_beat(3); cpl_beat(0);
        s_cpl_tvalid = 1'b0;
        #1;
        check("rr_drained", outstanding, 0);

        // backpressure hold, only channel 2 (rr_ptr now 1)
        s_cmd_tvalid = 4'b0100; m_cmd_tready = 1'b0;
        #1;
        check("bp_grant", s_cmd_tready, onehot(2));
        exp_cmd.push_back(payload(2));
        step();
        for (int i = 0; i < 5; i++) begin
          check("bp_tready_zero", s_cmd_tready, '0);
          check("bp_valid_hold", m_cmd_tvalid, 1);
          check("bp_data_hold", m_cmd_tdata, payload(2));
          step();
        end
        check("bp_outstanding", outstanding, 1);
        s_cmd_tvalid = '0; m_cmd_tready = 1'b1;
        step();
        check("bp_released", m_cmd_tvalid, 0);
        cpl_beat(2);
        s_cpl_tvalid = 1'b0;

        // fill tag FIFO (rr_ptr now 3)
        s_cmd_tvalid = '1;
        for (int i = 0; i < 8; i++) begin
          #1;
          check("fill_grant", s_cmd_tready, onehot((3 + i) % 4));
          exp_cmd.push_back(payload((3 + i) % 4));
          step();
        end
        #1;
        check("full_outstanding", outstanding, 8);
        check("full_no_ready", s_cmd_tready, '0);
        step();
        check("full_still_blocked", s_cmd_tready, '0);
        check("full_reg_cleared", m_cmd_tvalid, 0);
        set_cpl_data();
        s_cpl_tvalid = 1'b1;
        expect_cpl(3);
        #1;
        check("full_pop_no_grant", s_cmd_tready, '0);
        check("full_pop_cpl_ready", s_cpl_tready, 1);
        step();
        s_cpl_tvalid = 1'b0;
        #1;
        check("after_pop_outstanding", outstanding, 7);
        check("after_pop_grant", s_cmd_tready, onehot(3));
        exp_cmd.push_back(payload(3));
        step();
        s_cmd_tvalid = '0;
        #1;
        check("refill_outstanding", outstanding, 8);
        for (int i = 0; i < 8; i++) cpl_beat(i % 4);
        s_cpl_tvalid = 1'b0;
        #1;
        check("fill_drained", outstanding, 0);

        // issue 3,1,3 then stall completion for channel 1 (rr_ptr now 0)
        s_cmd_tvalid = 4'b1000;
        #1; check("ord_grant_a", s_cmd_tready, onehot(3));
        exp_cmd.push_back(payload(3)); step();
        s_cmd_tvalid = 4'b0010;
        #1; check("ord_grant_b", s_cmd_tready, onehot(1));
        exp_cmd.push_back(payload(1)); step();
        s_cmd_tvalid = 4'b1000;
        #1; check("ord_grant_c", s_cmd_tready, onehot(3));
        exp_cmd.push_back(payload(3)); step();
        s_cmd_tvalid = '0;
        step();
        m_cpl_tready = 4'b1101;
        set_cpl_data(); s_cpl_tvalid = 1'b1;
        #1;
        check("ord_cpl_route_a", m_cpl_tvalid, onehot(3));
        check("ord_cpl_ready_a", s_cpl_tready, 1);
        expect_cpl(3);
        step();
        set_cpl_data();
        #1;
        check("ord_cpl_route_b", m_cpl_tvalid, onehot(1));
        check("ord_cpl_stall", s_cpl_tready, 0);
        step();
        check("ord_cpl_stall_hold", s_cpl_tready, 0);
        check("ord_stall_outstanding", outstanding, 2);
        m_cpl_tready = '1;
        #1;
        check("ord_cpl_release", s_cpl_tready, 1);
        expect_cpl(1);
        step();
        cpl_beat(3);
        s_cpl_tvalid = 1'b0;
        #1;
        check("ord_drained", outstanding, 0);

        // orphan completion
        set_cpl_data(); s_cpl_tvalid = 1'b1;
        #1;
        check("orph_ready", s_cpl_tready, 1);
        check("orph_no_route", m_cpl_tvalid, '0);
        check("orph_not_yet", orphan_cpl, 0);
        step();
        s_cpl_tvalid = 1'b0;
        check("orph_pulse", orphan_cpl, 1);
        check("orph_outstanding", outstanding, 0);
        step();
        check("orph_pulse_end", orphan_cpl, 0);

        // disabling a channel leaves its in-flight command and tag intact
        s_cmd_tvalid = 4'b0001;
        #1; check("dis_grant", s_cmd_tready, onehot(0));
        exp_cmd.push_back(payload(0)); step();
        ch_en = 4'b1110;
        #1; check("dis_blocked", s_cmd_tready, '0);
        step();
        s_cmd_tvalid = '0;
        cpl_beat(0);
        s_cpl_tvalid = 1'b0;
        ch_en = '1;

        // masked channels alternate, then reset mid-stream (rr_ptr now 1)
        ch_en = 4'b1010; s_cmd_tvalid = '1;
        for (int i = 0; i < 4; i++) begin
          #1;
          check("mask_grant", s_cmd_tready, onehot((i % 2 == 1) ? 3 : 1));
          if (i < 3) exp_cmd.push_back(payload((i % 2 == 1) ? 3 : 1));
          step();
        end
        areset = 1'b1;
        #1;
        check("midrst_tready", s_cmd_tready, '0);
        check("midrst_cpl_ready", s_cpl_tready, 0);
        step();
        check("midrst_cmd_valid", m_cmd_tvalid, 0);
        check("midrst_outstanding", outstanding, 0);
        areset = 1'b0; s_cmd_tvalid = '0; ch_en = '1;
        step();
        set_cpl_data(); s_cpl_tvalid = 1'b1;
        #1;
        check("midrst_cpl_no_route", m_cpl_tvalid, '0);
        step();
        s_cpl_tvalid = 1'b0;
        check("midrst_orphan", orphan_cpl, 1);
        step();
        done = 1'b1;
      end
      begin : mon
        while (!done) begin
          @(negedge aclk);
          if (!areset && m_cmd_tvalid && m_cmd_tready) begin
            if (exp_cmd.size() == 0) begin
              checks++; failures++;
              $display("FAIL cmd_unexpected got=%0h exp=none", m_cmd_tdata);
            end else begin
              check("cmd_data", m_cmd_tdata, exp_cmd.pop_front());
            end
          end
          if (s_cpl_tvalid && s_cpl_tready && (m_cpl_tvalid != '0)) begin
            if (exp_cpl.size() == 0) begin
              checks++; failures++;
              $display("FAIL cpl_unexpected got=%0h exp=none", m_cpl_tvalid);
            end else begin
              cpl_exp_t e;
              e = exp_cpl.pop_front();
              check("cpl_route", m_cpl_tvalid, e.vld);
              check("cpl_data", m_cpl_tdata, e.data);
            end
          end
        end
      end
    join

    check("cmd_queue_empty", exp_cmd.size(), 0);
    check("cpl_queue_empty", exp_cpl.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
